// File: rtl/load_store_unit.sv
// Load/store sequencer: lane select, sign/zero extension, misalignment faults, and sub-word stores done as read-modify-write.
// Takes one request at a time. A response is held until accepted, and mem_we pulses for exactly one cycle per store.
module load_store_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic        fault_q, fault_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_fault;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'h0, b};
      3'b101:  load_extract = {16'h0, h};
      default: load_extract = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] a, input logic [2:0] f3);
    logic [31:0] m;
    m = w;
    case (f3)
      3'b000:  m[{a, 3'b000} +: 8] = d[7:0];
      3'b001:  m[{a[1], 4'b0000} +: 16] = d[15:0];
      default: m = d;
    endcase
    store_merge = m;
  endfunction

  // Unsigned load encodings are illegal for stores; reserved encodings fault for both.
  always_comb begin
    req_fault = 1'b0;
    case (req_funct3)
      3'b000:         req_fault = 1'b0;
      3'b001:         req_fault = req_addr[0];
      3'b010:         req_fault = |req_addr[1:0];
      3'b100, 3'b101: req_fault = req_store | (req_funct3[0] & req_addr[0]);
      default:        req_fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          store_d  = req_store;
          fault_d  = req_fault;
          rdata_d  = '0;
          cnt_d    = '0;
          if (req_fault) begin
            state_d = RESP;
          end else if (req_store && (req_funct3 == 3'b010)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      READ: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          word_d = mem_rd;
          if (store_q) begin
            state_d = WRITE;
          end else begin
            rdata_d = load_extract(mem_rd, addr_q[1:0], funct3_q);
            state_d = RESP;
          end
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_fault = fault_q;
    mem_we    = (state_q == WRITE) && !reset;
    mem_addr  = (state_q == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    mem_wd    = (state_q == WRITE) ? store_merge(word_q, wdata_q, addr_q[1:0], funct3_q) : 32'h0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word memory model, a response scoreboard, and a write monitor.
module tb_load_store_unit;
  localparam int MW = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_rdata, mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  load_store_unit #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:63];
  logic        pl_we = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_dat = '0;
  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
    else if (pl_we) mem[pl_idx] <= pl_dat;
  end

  typedef struct { int c; logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t wr_q[$];
  always @(negedge clk) if (mem_we) wr_q.push_back('{cyc, mem_addr, mem_wd});

  typedef struct { logic [31:0] rdata; bit fault; int lat; bit wr; logic [31:0] wd; int wcyc; } exp_t;
  exp_t exp_q[$];

  task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
    pl_idx = idx; pl_dat = dat; pl_we = 1'b1;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL accept_timeout: req_ready=%b required 1", req_ready); end
    e0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output int lat, output bit tmo);
    int n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    tmo = !rsp_valid;
    lat = cyc - e0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b required 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
    checks++; if (mem_wd !== 32'h0) begin errors++; $display("FAIL reset_mem_wd: got %h required 0", mem_wd); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h required 0", rsp_rdata); end
    checks++; if (rsp_fault !== 1'b0) begin errors++; $display("FAIL reset_rsp_fault: got %b required 0", rsp_fault); end
  endtask

  // Requests issued back to back: each new one goes in right after the previous handshake.
  task automatic test_loads();
    logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b000};
    logic [31:0] ad [6] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10, 32'h10};
    logic [31:0] ex [6] = '{32'hFFFFFF88, 32'h00000088, 32'h0000AABB, 32'hFFFF8899, 32'h8899AABB, 32'hFFFFFFBB};
    int lat; bit tmo; exp_t e;
    preload(6'd4, 32'h8899AABB);
    wr_q.delete();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{ex[i], 1'b0, MW + 2, 1'b0, 32'h0, 0});
      do_req(1'b0, f3[i], ad[i], 32'h0);
      get_rsp(lat, tmo);
      e = exp_q.pop_front();
      checks++; if (tmo) begin errors++; $display("FAIL load%0d_timeout: rsp_valid=%b required 1", i, rsp_valid); end
      checks++; if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL load%0d_rdata: got %h required %h", i, rsp_rdata, e.rdata); end
      checks++; if (rsp_fault !== e.fault || lat != e.lat) begin errors++; $display("FAIL load%0d_fault_lat: got %b/%0d required %b/%0d", i, rsp_fault, lat, e.fault, e.lat); end
      @(posedge clk); #1;
    end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL load_no_write: got %0d writes required 0", wr_q.size()); end
  endtask

  task automatic test_stores();
    logic [2:0]  f3 [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ad [3] = '{32'h11, 32'h12, 32'h14};
    logic [31:0] wd [3] = '{32'h000000CC, 32'h00001234, 32'hDEADBEEF};
    logic [31:0] ex [3] = '{32'h8899CCBB, 32'h1234AABB, 32'hDEADBEEF};
    int lat; bit tmo; exp_t e; wr_t w;
    for (int i = 0; i < 3; i++) begin
      preload(6'd4, 32'h8899AABB);
      wr_q.delete();
      if (f3[i] == 3'b010) exp_q.push_back('{32'h0, 1'b0, 2, 1'b1, ex[i], 1});
      else                 exp_q.push_back('{32'h0, 1'b0, MW + 3, 1'b1, ex[i], MW + 2});
      do_req(1'b1, f3[i], ad[i], wd[i]);
      get_rsp(lat, tmo);
      e = exp_q.pop_front();
      checks++; if (tmo || lat != e.lat) begin errors++; $display("FAIL store%0d_latency: got %0d required %0d", i, lat, e.lat); end
      checks++; if (rsp_rdata !== 32'h0 || rsp_fault !== 1'b0) begin errors++; $display("FAIL store%0d_rsp: got %h/%b required 0/0", i, rsp_rdata, rsp_fault); end
      checks++;
      if (wr_q.size() != 1) begin
        errors++; $display("FAIL store%0d_pulses: got %0d writes required 1", i, wr_q.size());
      end else begin
        w = wr_q.pop_front();
        if (w.d !== e.wd || w.a !== {ad[i][31:2], 2'b00} || w.c != e0 + e.wcyc) begin
          errors++;
          $display("FAIL store%0d_write: got %h@%h cyc+%0d required %h@%h cyc+%0d", i, w.d, w.a, w.c - e0, e.wd, {ad[i][31:2], 2'b00}, e.wcyc);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_faults();
    bit          st [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3 [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
    logic [31:0] ad [4] = '{32'h11, 32'h10, 32'h13, 32'h10};
    int lat; bit tmo; exp_t e;
    wr_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{32'h0, 1'b1, 1, 1'b0, 32'h0, 0});
      do_req(st[i], f3[i], ad[i], 32'hFFFFFFFF);
      get_rsp(lat, tmo);
      e = exp_q.pop_front();
      checks++; if (tmo || lat != e.lat) begin errors++; $display("FAIL fault%0d_latency: got %0d required %0d", i, lat, e.lat); end
      checks++; if (rsp_fault !== e.fault || rsp_rdata !== e.rdata) begin errors++; $display("FAIL fault%0d_rsp: got %b/%h required 1/0", i, rsp_fault, rsp_rdata); end
      @(posedge clk); #1;
    end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL fault_no_write: got %0d writes required 0", wr_q.size()); end
  endtask

  task automatic test_stall();
    int lat; bit tmo; exp_t e;
    preload(6'd4, 32'h8899AABB);
    wr_q.delete();
    rsp_ready = 1'b0;
    exp_q.push_back('{32'hFFFFFFAA, 1'b0, MW + 2, 1'b0, 32'h0, 0});
    do_req(1'b0, 3'b000, 32'h11, 32'h0);
    get_rsp(lat, tmo);
    e = exp_q.pop_front();
    checks++; if (tmo || lat != e.lat) begin errors++; $display("FAIL stall_latency: got %0d required %0d", lat, e.lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || req_ready !== 1'b0 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b d=%h rdy=%b we=%b required 1/%h/0/0", i, rsp_valid, rsp_rdata, req_ready, mem_we, e.rdata);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got v=%b rdy=%b required 0/1", rsp_valid, req_ready); end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL stall_no_write: got %0d writes required 0", wr_q.size()); end
  endtask

  task automatic test_reset_mid_write();
    preload(6'd4, 32'h8899AABB);
    wr_q.delete();
    do_req(1'b1, 3'b000, 32'h11, 32'h000000CC);
    repeat (MW + 1) begin @(posedge clk); #1; end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL midrst_in_write: mem_we=%b required 1", mem_we); end
    reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_we_masked: got %b required 0", mem_we); end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL midrst_idle: got rdy=%b addr=%h required 1/0", req_ready, mem_addr); end
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp: got %b required 0", rsp_valid); end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL midrst_no_write: got %0d writes required 0", wr_q.size()); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_stall();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
